wb_mem_responder: RTL and testbench
===================================

# wb_mem_responder

Pipelined Wishbone B4 slave with a small on-chip word memory, fixed response latency and optional pseudo-random stall injection. It is the responder end of the classic pipelined Wishbone bus. It serves as the synthesizable target for bus masters and interconnect in SoC simulation and FPGA bring-up, so every master-side protocol path (stall, back-to-back, error, abort) can be exercised.

## Interface
Parameters:
- DEPTH, 256 — memory size in 32-bit words; power of two, 4..4096.
- LATENCY, 2 — cycles from request acceptance to ACK/ERR; 1..15.
- STALL_EN, 0 — 1 enables pseudo-random STALL insertion.
- LFSR_SEED, 8'hA5 — initial stall-LFSR state; a value of 0 is replaced by 8'h01.

Ports:
- clk  in  1  — single clock; all logic on the rising edge.
- reset_n  in  1  — asynchronous, active-low reset.
- cyc_i  in  1  — bus cycle.
- stb_i  in  1  — request strobe.
- we_i  in  1  — 1 = write.
- adr_i  in  adr_t  — byte address.
- sel_i  in  sel_t  — byte enables.
- dat_i  in  dat_t  — write data.
- stall_o  out  1  — slave cannot accept a request this cycle.
- ack_o  out  1  — successful completion.
- err_o  out  1  — error completion.
- dat_o  out  dat_t  — read data, valid while ack_o is high for a read.

## Operation
- Accept: a request is accepted when cyc_i && stb_i && !stall_o at a clock edge.
- Address decode:
  - Word index = adr_i[2 +: log2(DEPTH)].
  - Any other set bit of adr_i is out of range, including adr_i[1:0] != 0.
- In-range write: at the accepting edge, memory bytes with sel_i[b]=1 take dat_i[8b+:8]. Other bytes are unchanged. The response is ACK.
- In-range read: memory is read at the accepting edge, and that data is carried to the response. The response is ACK.
- Out-of-range access: no memory change. The response is ERR, with dat_o = 0.
- Response pipeline: a LATENCY-stage shift register of {valid, err, data}.
  - Stage 0 loads at accept.
  - ack_o = valid && !err of the last stage; err_o = valid && err of the last stage.
  - ack_o and err_o are never both high.
- Abort: when cyc_i is sampled low, all pipeline valids are cleared at that edge, and no ACK/ERR is issued for in-flight requests. Writes already accepted stay committed.
- Stall:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle.
  - stall_o register next = STALL_EN && (lfsr[1:0] == 2'b00), about 25% duty.
  - With STALL_EN=0, stall_o is constant 0.
- Memory contents are not reset.

## Timing
- Reset values: stall_o=0, ack_o=0, err_o=0, dat_o=0, pipeline valids 0, LFSR=LFSR_SEED (or 8'h01 if the seed is 0).
- Latency: a request accepted at edge k produces ACK/ERR high for exactly one cycle after edge k+LATENCY-1, i.e. LATENCY cycles after accept. LATENCY=1 responds in the cycle following acceptance.
- Throughput: one request per cycle when not stalled. N back-to-back accepts yield N back-to-back responses, in order.
- Read-after-write: a write accepted at edge k is visible to a read accepted at edge k+1.
- ACK/ERR always arrives within 15 cycles of acceptance, satisfying the 16-cycle handshake bound.
- stall_o is registered and independent of inputs. Master hold-during-stall is the master's obligation; the slave only samples at accept.
- cyc_i low with stb_i high does not constitute a request.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronously) and in-flight responses are lost.

## Structure
- wb_pkg (existing): adr_t, dat_t, sel_t.
- Add to wb_pkg:
  - resp_t packed struct {logic valid; logic err; dat_t dat;}.
  - localparam WB_MAX_LATENCY = 15.
- Sub-module wb_stall_lfsr: 8-bit LFSR with SEED parameter and a registered stall output. It is reusable by other test slaves.
- Top level: decode, memory array, resp_t pipeline array.

## Test plan
- Write 32'hDEADBEEF to adr 0x10 with sel 4'hF, then read 0x10 → read ACK exactly LATENCY cycles after accept, dat_o=32'hDEADBEEF.
- Partial write: sel=4'b0101 with 32'h11223344 over 32'hDEADBEEF at 0x10 → readback 32'hDE22BE44.
- Back-to-back: 4 reads at 0x0,0x4,0x8,0xC in consecutive cycles, STALL_EN=0 → 4 consecutive ACK cycles, data in request order, no gaps.
- Error: read adr 4*DEPTH (and separately adr 0x2) → err_o=1, ack_o=0, dat_o=0 after LATENCY; memory unchanged.
- Abort: LATENCY=4, accept 2 reads, drop cyc_i after 1 cycle → no ack_o/err_o for either request. A write accepted before the abort is readable afterwards.
- Stall: STALL_EN=1, 200 random requests with the protocol checker attached → zero checker failures, ACK+ERR count equals accept count, stall_o toggles. Reset mid-stream → all outputs 0 while reset_n=0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone B4 types plus the response-pipeline record used by test slaves.
package wb_pkg;
    typedef logic [31:0] adr_t;
    typedef logic [31:0] dat_t;
    typedef logic [3:0]  sel_t;
    typedef struct packed {
        logic valid;
        logic err;
        dat_t dat;
    } resp_t;
    localparam int WB_MAX_LATENCY = 15;
endpackage

// File: rtl/wb_stall_lfsr.sv
// wb_stall_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) driving a registered ~25% stall pattern.
module wb_stall_lfsr #(
    parameter bit         ENABLE = 1'b1,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input  logic clk,
    input  logic reset_n,
    output logic stall_o
);
    // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
    localparam logic [7:0] INIT = (SEED == 8'h00) ? 8'h01 : SEED;
    logic [7:0] lfsr_q, lfsr_d;
    logic       stall_q, stall_d;
    always_comb begin
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        stall_d = ENABLE && (lfsr_q[1:0] == 2'b00);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q  <= INIT;
            stall_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            stall_q <= stall_d;
        end
    end
    assign stall_o = stall_q;
endmodule

// File: rtl/wb_mem_responder.sv
// wb_mem_responder: pipelined Wishbone B4 slave with word memory, fixed ACK/ERR latency
// and optional pseudo-random stall injection.
module wb_mem_responder
    import wb_pkg::*;
#(
    parameter int         DEPTH     = 256,
    parameter int         LATENCY   = 2,
    parameter bit         STALL_EN  = 1'b0,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cyc_i,
    input  logic stb_i,
    input  logic we_i,
    input  adr_t adr_i,
    input  sel_t sel_i,
    input  dat_t dat_i,
    output logic stall_o,
    output logic ack_o,
    output logic err_o,
    output dat_t dat_o
);
    localparam int   AW       = $clog2(DEPTH);
    localparam adr_t IDX_MASK = adr_t'(DEPTH - 1) << 2;

    if (LATENCY < 1 || LATENCY > WB_MAX_LATENCY) begin : g_bad_latency
        $error("wb_mem_responder: LATENCY must be 1..%0d", WB_MAX_LATENCY);
    end

    dat_t                  mem [DEPTH];
    resp_t [LATENCY-1:0]   pipe_q, pipe_d;
    logic                  accept, oor;
    logic [AW-1:0]         idx;

    wb_stall_lfsr #(.ENABLE(STALL_EN), .SEED(LFSR_SEED)) u_stall (
        .clk     (clk),
        .reset_n (reset_n),
        .stall_o (stall_o)
    );

    assign accept = cyc_i && stb_i && !stall_o;
    assign idx    = adr_i[2 +: AW];
    // Any address bit outside the word index, including byte offset bits, is an error.
    assign oor    = |(adr_i & ~IDX_MASK);

    always_comb begin
        pipe_d[0].valid = accept;
        pipe_d[0].err   = oor;
        pipe_d[0].dat   = (oor || we_i) ? '0 : mem[idx];
        for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
        if (!cyc_i) for (int i = 0; i < LATENCY; i++) pipe_d[i].valid = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pipe_q <= '0;
        else          pipe_q <= pipe_d;
    end

    // Memory is intentionally not reset; accepted writes survive aborts and resets.
    always_ff @(posedge clk) begin
        if (accept && we_i && !oor)
            for (int b = 0; b < 4; b++)
                if (sel_i[b]) mem[idx][8*b +: 8] <= dat_i[8*b +: 8];
    end

    assign ack_o = pipe_q[LATENCY-1].valid && !pipe_q[LATENCY-1].err;
    assign err_o = pipe_q[LATENCY-1].valid &&  pipe_q[LATENCY-1].err;
    assign dat_o = ack_o ? pipe_q[LATENCY-1].dat : '0;
endmodule

// File: tb/tb_wb_mem_responder.sv
// tb_wb_mem_responder: directed vectors plus random traffic against a transaction-level model
// for a stalling LATENCY=4 responder and a non-stalling LATENCY=1 twin on the same bus.
module tb_wb_mem_responder;
    import wb_pkg::*;
    localparam int         DEPTH = 16;
    localparam int         L     = 4;
    localparam logic [7:0] SEED  = 8'hA5;

    logic clk = 1'b0, reset_n = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0;
    adr_t adr = '0;
    sel_t sel = '0;
    dat_t dat = '0;
    logic stall, ack, err, stall0, ack0, err0;
    dat_t dato, dato0;

    always #5 clk = ~clk;

    wb_mem_responder #(.DEPTH(DEPTH), .LATENCY(L), .STALL_EN(1'b1), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset_n(reset_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
        .sel_i(sel), .dat_i(dat), .stall_o(stall), .ack_o(ack), .err_o(err), .dat_o(dato));

    wb_mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .STALL_EN(1'b0), .LFSR_SEED(SEED)) dut0 (
        .clk(clk), .reset_n(reset_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
        .sel_i(sel), .dat_i(dat), .stall_o(stall0), .ack_o(ack0), .err_o(err0), .dat_o(dato0));

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic bit out_of_range(input adr_t a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    // Reference model: word memory, a due-cycle wheel of expected responses, stall sequence.
    logic [31:0] mmem [DEPTH];
    bit          known [DEPTH];
    bit          ev [16], ee [16], edc [16];
    logic [31:0] ed [16];
    logic [7:0]  lf = SEED;
    bit          es, p0v, p0e, p0c, m_oor, m_acc;
    logic [31:0] p0d;
    logic        stall_prev = 1'b0;
    int          t = 0, m_s, m_ix, acc_n = 0, resp_n = 0, stall_tog = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_stall", stall, 0);
            chk("rst_ack", ack, 0);
            chk("rst_err", err, 0);
            chk("rst_dat", dato, 0);
            chk("rst_ack0", ack0, 0);
            chk("rst_err0", err0, 0);
            for (int i = 0; i < 16; i++) ev[i] = 0;
            p0v = 0;
            lf = SEED;
            es = 0;
        end else begin
            m_s = t % 16;
            chk("stall", stall, es);
            chk("ack", ack, ev[m_s] && !ee[m_s]);
            chk("err", err, ev[m_s] && ee[m_s]);
            if (ev[m_s] && !ee[m_s] && edc[m_s]) chk("rdata", dato, ed[m_s]);
            if (ev[m_s] && ee[m_s]) chk("err_dat", dato, 0);
            ev[m_s] = 0;
            chk("stall0", stall0, 0);
            chk("ack0", ack0, p0v && !p0e);
            chk("err0", err0, p0v && p0e);
            if (p0v && !p0e && p0c) chk("rdata0", dato0, p0d);
            if (ack || err) resp_n++;
            if (stall !== stall_prev) stall_tog++;
            stall_prev = stall;
            m_oor = out_of_range(adr);
            m_ix  = m_oor ? 0 : int'(adr / 4);
            if (!cyc) for (int i = 0; i < 16; i++) ev[i] = 0;
            m_acc = cyc && stb && !stall;
            p0v = cyc && stb;
            p0e = m_oor;
            p0d = mmem[m_ix];
            p0c = !we && !m_oor && known[m_ix];
            if (m_acc) begin
                acc_n++;
                ev[(t + L) % 16]  = 1;
                ee[(t + L) % 16]  = m_oor;
                ed[(t + L) % 16]  = mmem[m_ix];
                edc[(t + L) % 16] = !we && !m_oor && known[m_ix];
                if (we && !m_oor) begin
                    for (int b = 0; b < 4; b++) if (sel[b]) mmem[m_ix][8*b +: 8] = dat[8*b +: 8];
                    if (sel == 4'hF) known[m_ix] = 1;
                end
            end
            es = (lf[1:0] == 2'b00);
            lf = lfsr_next(lf);
            t++;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic w, input adr_t a, input sel_t s, input dat_t d, output int n);
        bit ok = 0;
        n = 0;
        cyc = 1; stb = 1; we = w; adr = a; sel = s; dat = d;
        while (!ok && n < 64) begin
            @(negedge clk);
            ok = !stall;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: request at %h never accepted", a);
        end
        stb = 0;
    endtask

    task automatic expect_resp(input string name, input logic eack, input logic eerr,
                               input logic cdat, input dat_t edat);
        repeat (L - 1) @(posedge clk);
        @(negedge clk);
        chk({name, "_ack"}, ack, eack);
        chk({name, "_err"}, err, eerr);
        if (cdat) chk({name, "_dat"}, dato, edat);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic w; adr_t a; sel_t s; dat_t d;
        logic eack; logic eerr; logic cdat; dat_t edat;
    } vec_t;
    vec_t tv [14];
    dat_t init_dat [DEPTH];

    initial begin
        int n, n2, a0, r0;
        tv[0]  = '{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0};
        tv[1]  = '{1'b0, 32'h10, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        tv[2]  = '{1'b1, 32'h10, 4'h5, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h0};
        tv[3]  = '{1'b0, 32'h10, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDE22BE44};
        tv[4]  = '{1'b0, 32'h40, 4'hF, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
        tv[5]  = '{1'b0, 32'h02, 4'hF, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
        tv[6]  = '{1'b1, 32'h00, 4'hF, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 32'h0};
        tv[7]  = '{1'b1, 32'h40, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'h0};
        tv[8]  = '{1'b0, 32'h00, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0BADF00D};
        tv[9]  = '{1'b1, 32'h12, 4'hF, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
        tv[10] = '{1'b0, 32'h10, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDE22BE44};
        tv[11] = '{1'b1, 32'h3C, 4'hF, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h0};
        tv[12] = '{1'b0, 32'h3C, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'h12345678};
        tv[13] = '{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0};

        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            init_dat[i] = $urandom;
            issue(1'b1, adr_t'(i * 4), 4'hF, init_dat[i], n);
        end
        repeat (L + 1) @(posedge clk);
        #1;

        // Back-to-back reads on the non-stalling twin: four consecutive ACKs in order.
        cyc = 1; stb = 1; we = 0; adr = 32'h0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) chk("b2b_idle", ack0, 0);
            else begin
                chk($sformatf("b2b%0d_ack", k), ack0, 1);
                chk($sformatf("b2b%0d_dat", k), dato0, init_dat[k-1]);
            end
            @(posedge clk);
            #1;
            adr = adr_t'((k + 1) * 4);
            if (k == 3) stb = 0;
        end
        @(negedge clk);
        chk("b2b_after", ack0, 0);
        repeat (L + 1) @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            issue(tv[i].w, tv[i].a, tv[i].s, tv[i].d, n);
            expect_resp($sformatf("vec%0d", i), tv[i].eack, tv[i].eerr, tv[i].cdat, tv[i].edat);
        end

        // Abort: two reads in flight, cyc dropped; the earlier write stays committed.
        issue(1'b1, 32'h20, 4'hF, 32'hCAFEF00D, n);
        expect_resp("abort_wr", 1'b1, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 32'h20, 4'hF, 32'h0, n);
        issue(1'b0, 32'h24, 4'hF, 32'h0, n2);
        cyc = 0;
        repeat (L + 2) begin
            @(negedge clk);
            if (n2 <= 2) begin
                chk("abort_ack", ack, 0);
                chk("abort_err", err, 0);
            end
        end
        @(posedge clk);
        #1;
        cyc = 1;
        issue(1'b0, 32'h20, 4'hF, 32'h0, n);
        expect_resp("post_abort", 1'b1, 1'b0, 1'b1, 32'hCAFEF00D);

        // Random traffic with stalls: every accept gets exactly one response.
        a0 = acc_n;
        r0 = resp_n;
        repeat (200) begin
            adr_t ra;
            ra = ($urandom_range(0, 7) == 0) ? adr_t'($urandom) : adr_t'($urandom_range(0, DEPTH - 1) * 4);
            issue(1'($urandom_range(0, 1)), ra, sel_t'($urandom_range(0, 15)), $urandom, n);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (L + 2) @(posedge clk);
        #1;
        chk("resp_count", 32'(resp_n - r0), 32'(acc_n - a0));
        chk("stall_toggles", 32'(stall_tog > 0), 1);

        // Reset while a read ACK is on the bus must clear outputs without a clock edge.
        issue(1'b0, 32'h20, 4'hF, 32'h0, n);
        repeat (L - 1) @(posedge clk);
        #1;
        chk("pre_rst_ack", ack, 1);
        reset_n = 0;
        #1;
        chk("async_rst_ack", ack, 0);
        chk("async_rst_dat", dato, 0);
        chk("async_rst_stall", stall, 0);
        chk("async_rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk);
        #1;
        issue(1'b0, 32'h20, 4'hF, 32'h0, n);
        expect_resp("post_rst", 1'b1, 1'b0, 1'b1, mmem[8]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
